packet_stream_arbiter: RTL and testbench



---
 rtl/packet_stream_arbiter_pkg.sv | 30 +++
 rtl/packet_stream_arbiter_if.sv | 37 +++
 rtl/packet_stream_arbiter_rr_encoder.sv | 35 +++
 rtl/packet_stream_arbiter.sv | 97 +++++++++
 tb/tb_packet_stream_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/packet_stream_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// packet_stream_arbiter_pkg: shared arbiter state encoding and helpers. Rev 1.0
// ============================================================================
package packet_stream_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_TAG    = 2'd1;
  localparam logic [1:0] ARB_STREAM = 2'd2;

  localparam logic [7:0] DEFAULT_TAG_BASE = 8'hA0;

  typedef enum logic [1:0] {
    ST_IDLE   = ARB_IDLE,
    ST_TAG    = ARB_TAG,
    ST_STREAM = ARB_STREAM
  } arb_state_e;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/packet_stream_arbiter_if.sv
`default_nettype none
// ============================================================================
// packet_stream_arbiter_if: producer-side and downstream stream bundle. Rev 1.0
// ============================================================================
interface packet_stream_arbiter_if
  import packet_stream_arbiter_pkg::*;
#(
  parameter int SOURCE_COUNT = 3,
  parameter int DATA_WIDTH   = 8
);
  localparam int GRANT_WIDTH = clog2(SOURCE_COUNT);

  logic [SOURCE_COUNT*DATA_WIDTH-1:0] in_data;
  logic [SOURCE_COUNT-1:0]            in_valid;
  logic [SOURCE_COUNT-1:0]            in_ready;
  logic [SOURCE_COUNT-1:0]            in_last;
  logic [DATA_WIDTH-1:0]              out_data;
  logic                               out_valid;
  logic                               out_ready;
  logic                               out_last;
  logic [GRANT_WIDTH-1:0]             grant_index;
  logic                               busy;

  // Arbiter side.
  modport master (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, grant_index, busy
  );

  // Producers plus downstream consumer side.
  modport slave (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, grant_index, busy
  );

endinterface
`default_nettype wire

// File: rtl/packet_stream_arbiter_rr_encoder.sv
`default_nettype none
// ============================================================================
// round_robin_priority_encoder: first requester after last_grant, wrapping. Rev 1.0
// ============================================================================
module round_robin_priority_encoder
  import packet_stream_arbiter_pkg::*;
#(
  parameter int N         = 3,
  parameter int IDX_WIDTH = clog2(N)
) (
  input  logic [N-1:0]         request_i,
  input  logic [IDX_WIDTH-1:0] last_grant_i,
  output logic                 grant_valid_o,
  output logic [IDX_WIDTH-1:0] grant_index_o
);

  logic [2*N-1:0] doubled;
  logic [2*N-1:0] rotated;

  // Doubling the request vector turns the wrap-around scan into a plain shift.
  always_comb begin
    doubled       = {request_i, request_i};
    rotated       = doubled >> (int'(last_grant_i) + 1);
    grant_valid_o = 1'b0;
    grant_index_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        grant_valid_o = 1'b1;
        grant_index_o = IDX_WIDTH'((int'(last_grant_i) + 1 + i) % N);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/packet_stream_arbiter.sv
`default_nettype none
// ============================================================================
// packet_stream_arbiter: whole-packet round-robin merge with optional tag. Rev 1.0
// ============================================================================
module packet_stream_arbiter
  import packet_stream_arbiter_pkg::*;
#(
  parameter int                    SOURCE_COUNT = 3,
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    TAG_ENABLE   = 1,
  parameter logic [DATA_WIDTH-1:0] TAG_BASE     = DATA_WIDTH'(DEFAULT_TAG_BASE)
) (
  input  logic                   clock,
  input  logic                   reset,
  packet_stream_arbiter_if.master bus
);

  localparam int GRANT_WIDTH = clog2(SOURCE_COUNT);

  arb_state_e             state_q, state_d;
  logic [GRANT_WIDTH-1:0] grant_q, grant_d;
  logic [GRANT_WIDTH-1:0] last_grant_q, last_grant_d;

  logic                   pick_valid;
  logic [GRANT_WIDTH-1:0] pick_index;

  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   sel_valid;
  logic                   sel_last;

  round_robin_priority_encoder #(
    .N         (SOURCE_COUNT),
    .IDX_WIDTH (GRANT_WIDTH)
  ) u_rr (
    .request_i     (bus.in_valid),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (pick_valid),
    .grant_index_o (pick_index)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GRANT_WIDTH'(SOURCE_COUNT - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    sel_data  = bus.in_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    sel_valid = bus.in_valid[grant_q];
    sel_last  = bus.in_last[grant_q];
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    bus.in_ready  = '0;
    bus.busy      = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d      = pick_index;
          last_grant_d = pick_index;
          state_d      = (TAG_ENABLE != 0) ? ST_TAG : ST_STREAM;
        end
      end
      ST_TAG: begin
        bus.out_valid = 1'b1;
        bus.out_data  = TAG_BASE + DATA_WIDTH'(grant_q);
        if (bus.out_ready) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        // Packet lock: only the granted source is visible until its last beat.
        bus.out_data          = sel_data;
        bus.out_valid         = sel_valid;
        bus.out_last          = sel_last;
        bus.in_ready[grant_q] = bus.out_ready;
        if (sel_valid && bus.out_ready && sel_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.grant_index = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_packet_stream_arbiter.sv
`default_nettype none
// ============================================================================
// tb_packet_stream_arbiter: directed scenarios plus randomized packet traffic. Rev 1.0
// ============================================================================
module tb_packet_stream_arbiter;

  localparam int NS   = 3;
  localparam int DW   = 8;
  localparam int MAXB = 64;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  packet_stream_arbiter_if #(.SOURCE_COUNT(NS), .DATA_WIDTH(DW)) bus ();
  packet_stream_arbiter_if #(.SOURCE_COUNT(NS), .DATA_WIDTH(DW)) bus2 ();

  packet_stream_arbiter #(
    .SOURCE_COUNT (NS), .DATA_WIDTH (DW), .TAG_ENABLE (1), .TAG_BASE (8'hA0)
  ) u_dut (
    .clock (clock), .reset (reset), .bus (bus)
  );

  packet_stream_arbiter #(
    .SOURCE_COUNT (NS), .DATA_WIDTH (DW), .TAG_ENABLE (0), .TAG_BASE (8'hA0)
  ) u_dut_nt (
    .clock (clock), .reset (reset), .bus (bus2)
  );

  int checks   = 0;
  int failures = 0;

  // Per-source beat lists presented to the tagged instance.
  logic [DW-1:0] sd [NS][MAXB];
  bit            sl [NS][MAXB];
  int            sn [NS];
  int            sp [NS];
  bit            en [NS];
  bit            acc[NS];

  task automatic clear_sources();
    for (int s = 0; s < NS; s++) begin
      sn[s] = 0; sp[s] = 0; en[s] = 1'b0; acc[s] = 1'b0;
    end
    bus.in_valid = '0; bus.in_data = '0; bus.in_last = '0; bus.out_ready = 1'b0;
    bus2.in_valid = '0; bus2.in_data = '0; bus2.in_last = '0; bus2.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_sources();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic add_beat(input int s, input logic [DW-1:0] d, input bit last);
    sd[s][sn[s]] = d;
    sl[s][sn[s]] = last;
    sn[s]++;
  endtask

  // One clock: retire beats accepted last cycle, present next heads, sample at negedge.
  task automatic step(input bit rdy);
    @(posedge clock);
    #1;
    for (int s = 0; s < NS; s++) begin
      if (acc[s]) sp[s]++;
      if (en[s] && sp[s] < sn[s]) begin
        bus.in_valid[s]          = 1'b1;
        bus.in_data[s*DW +: DW]  = sd[s][sp[s]];
        bus.in_last[s]           = sl[s][sp[s]];
      end else begin
        bus.in_valid[s]          = 1'b0;
        bus.in_data[s*DW +: DW]  = '0;
        bus.in_last[s]           = 1'b0;
      end
    end
    bus.out_ready = rdy;
    @(negedge clock);
    for (int s = 0; s < NS; s++) acc[s] = bus.in_valid[s] & bus.in_ready[s];
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1);
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid cyc=%0d got=%b exp=0", i, bus.out_valid); end
      checks++; if (bus.in_ready !== 3'b000) begin failures++; $display("FAIL reset_in_ready cyc=%0d got=%b exp=000", i, bus.in_ready); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy cyc=%0d got=%b exp=0", i, bus.busy); end
      checks++; if (bus.grant_index !== 2'd0) begin failures++; $display("FAIL reset_grant cyc=%0d got=%0d exp=0", i, bus.grant_index); end
      checks++; if (bus.out_data !== 8'h00 || bus.out_last !== 1'b0) begin failures++; $display("FAIL reset_out_data cyc=%0d got=%h/%b exp=00/0", i, bus.out_data, bus.out_last); end
      checks++; if (bus2.out_valid !== 1'b0 || bus2.busy !== 1'b0) begin failures++; $display("FAIL reset_nt_idle cyc=%0d got=%b/%b exp=0/0", i, bus2.out_valid, bus2.busy); end
    end
  endtask

  task automatic test_single_source();
    int ev[6] = '{0, 1, 1, 1, 1, 0};
    int ed[6] = '{0, 'hA1, 'h11, 'h22, 'h33, 0};
    int el[6] = '{0, 0, 0, 0, 1, 0};
    int er[6] = '{0, 0, 1, 1, 1, 0};
    do_reset();
    add_beat(1, 8'h11, 1'b0); add_beat(1, 8'h22, 1'b0); add_beat(1, 8'h33, 1'b1);
    en[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      checks++; if (bus.out_valid !== 1'(ev[i])) begin failures++; $display("FAIL single_valid cyc=%0d got=%b exp=%0d", i, bus.out_valid, ev[i]); end
      if (ev[i] != 0) begin
        checks++; if (bus.out_data !== DW'(ed[i])) begin failures++; $display("FAIL single_data cyc=%0d got=%h exp=%h", i, bus.out_data, DW'(ed[i])); end
        checks++; if (bus.out_last !== 1'(el[i])) begin failures++; $display("FAIL single_last cyc=%0d got=%b exp=%0d", i, bus.out_last, el[i]); end
        checks++; if (bus.grant_index !== 2'd1) begin failures++; $display("FAIL single_grant cyc=%0d got=%0d exp=1", i, bus.grant_index); end
      end
      checks++; if (bus.in_ready[1] !== 1'(er[i])) begin failures++; $display("FAIL single_in_ready cyc=%0d got=%b exp=%0d", i, bus.in_ready[1], er[i]); end
      checks++; if (bus.busy !== 1'(ev[i])) begin failures++; $display("FAIL single_busy cyc=%0d got=%b exp=%0d", i, bus.busy, ev[i]); end
    end
  endtask

  task automatic test_round_robin();
    bit            xv[$];
    logic [DW-1:0] xd[$];
    bit            xl[$];
    int            pk[NS];
    int            last, s, n;
    do_reset();
    for (int i = 0; i < NS; i++) begin
      for (int p = 0; p < 2; p++) begin
        add_beat(i, DW'(16*(i+1) + 2*p), 1'b0);
        add_beat(i, DW'(16*(i+1) + 2*p + 1), 1'b1);
      end
      en[i] = 1'b1;
      pk[i] = 0;
    end
    // Every packet costs one decision bubble, one tag beat and its data beats.
    last = NS - 1;
    for (int k = 0; k < 2*NS; k++) begin
      s = -1;
      for (int j = 1; j <= NS && s < 0; j++)
        if (pk[(last + j) % NS] < 2) s = (last + j) % NS;
      xv.push_back(1'b0); xd.push_back('0); xl.push_back(1'b0);
      xv.push_back(1'b1); xd.push_back(DW'(8'hA0 + s)); xl.push_back(1'b0);
      for (int b = 0; b < 2; b++) begin
        xv.push_back(1'b1); xd.push_back(sd[s][2*pk[s] + b]); xl.push_back(b == 1);
      end
      pk[s]++;
      last = s;
    end
    xv.push_back(1'b0); xd.push_back('0); xl.push_back(1'b0);
    n = xv.size();
    for (int i = 0; i < n; i++) begin
      step(1'b1);
      checks++; if (bus.out_valid !== xv[i]) begin failures++; $display("FAIL rr_valid cyc=%0d got=%b exp=%b", i, bus.out_valid, xv[i]); end
      if (xv[i]) begin
        checks++; if (bus.out_data !== xd[i] || bus.out_last !== xl[i]) begin failures++; $display("FAIL rr_beat cyc=%0d got=%h/%b exp=%h/%b", i, bus.out_data, bus.out_last, xd[i], xl[i]); end
      end
    end
  endtask

  task automatic test_stall();
    int rd[11] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
    int ev[11] = '{0, 1, 1, 1, 1, 1, 1, 0, 1, 1, 0};
    int ed[11] = '{0, 'hA0, 'h01, 'h02, 'h03, 'h03, 'h03, 0, 'hA2, 'h77, 0};
    int el[11] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0};
    int eg[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 2};
    do_reset();
    add_beat(0, 8'h01, 1'b0); add_beat(0, 8'h02, 1'b0); add_beat(0, 8'h03, 1'b1);
    add_beat(2, 8'h77, 1'b1);
    en[0] = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i == 2) en[2] = 1'b1;
      step(1'(rd[i]));
      checks++; if (bus.out_valid !== 1'(ev[i])) begin failures++; $display("FAIL stall_valid cyc=%0d got=%b exp=%0d", i, bus.out_valid, ev[i]); end
      if (ev[i] != 0) begin
        checks++; if (bus.out_data !== DW'(ed[i]) || bus.out_last !== 1'(el[i])) begin failures++; $display("FAIL stall_beat cyc=%0d got=%h/%b exp=%h/%0d", i, bus.out_data, bus.out_last, DW'(ed[i]), el[i]); end
      end
      checks++; if (bus.grant_index !== 2'(eg[i])) begin failures++; $display("FAIL stall_grant cyc=%0d got=%0d exp=%0d", i, bus.grant_index, eg[i]); end
      if (i < 8) begin
        checks++; if (bus.in_ready[2] !== 1'b0) begin failures++; $display("FAIL stall_locked cyc=%0d got=%b exp=0", i, bus.in_ready[2]); end
      end
    end
  endtask

  task automatic test_single_beat_no_tag();
    do_reset();
    @(posedge clock); #1;
    bus2.in_valid = 3'b100; bus2.in_data = {8'h5A, 16'h0000}; bus2.in_last = 3'b100; bus2.out_ready = 1'b1;
    @(negedge clock);
    checks++; if (bus2.out_valid !== 1'b0) begin failures++; $display("FAIL nt_decide_valid got=%b exp=0", bus2.out_valid); end
    @(posedge clock); #1;
    @(negedge clock);
    checks++; if (bus2.out_valid !== 1'b1 || bus2.out_data !== 8'h5A) begin failures++; $display("FAIL nt_beat got=%b/%h exp=1/5a", bus2.out_valid, bus2.out_data); end
    checks++; if (bus2.out_last !== 1'b1) begin failures++; $display("FAIL nt_last got=%b exp=1", bus2.out_last); end
    checks++; if (bus2.in_ready !== 3'b100 || bus2.grant_index !== 2'd2) begin failures++; $display("FAIL nt_grant got=%b/%0d exp=100/2", bus2.in_ready, bus2.grant_index); end
    @(posedge clock); #1;
    bus2.in_valid = '0; bus2.in_last = '0; bus2.in_data = '0;
    @(negedge clock);
    checks++; if (bus2.busy !== 1'b0 || bus2.out_valid !== 1'b0) begin failures++; $display("FAIL nt_done got=%b/%b exp=0/0", bus2.busy, bus2.out_valid); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    for (int k = 0; k < 4; k++) add_beat(0, DW'(8'hC1 + k), k == 3);
    en[0] = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1);
    checks++; if (bus.out_data !== 8'hC2 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL rstmid_beat2 got=%h/%b exp=c2/1", bus.out_data, bus.out_valid); end
    reset = 1'b0;
    clear_sources();
    @(posedge clock); #1;
    @(negedge clock);
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 3'b000) begin failures++; $display("FAIL rstmid_outputs got=%b/%b exp=0/000", bus.out_valid, bus.in_ready); end
    checks++; if (bus.busy !== 1'b0 || bus.grant_index !== 2'd0) begin failures++; $display("FAIL rstmid_state got=%b/%0d exp=0/0", bus.busy, bus.grant_index); end
    reset = 1'b1;
    add_beat(0, 8'hE0, 1'b1); add_beat(1, 8'hE1, 1'b1);
    en[0] = 1'b1; en[1] = 1'b1;
    step(1'b1);
    step(1'b1);
    checks++; if (bus.out_data !== 8'hA0 || bus.grant_index !== 2'd0) begin failures++; $display("FAIL rstmid_regrant got=%h/%0d exp=a0/0", bus.out_data, bus.grant_index); end
    step(1'b1);
    checks++; if (bus.out_data !== 8'hE0 || bus.out_last !== 1'b1) begin failures++; $display("FAIL rstmid_dropped got=%h/%b exp=e0/1", bus.out_data, bus.out_last); end
  endtask

  task automatic test_random();
    logic [8:0]    exp_q[$];
    logic [8:0]    e;
    int            npk[NS];
    int            mp[NS];
    int            last, s, cyc;
    bit            any, prev_stall;
    logic [DW-1:0] prev_data;
    logic [NS-1:0] gmask;
    for (int round = 0; round < 4; round++) begin
      do_reset();
      for (int i = 0; i < NS; i++) begin
        npk[i] = $urandom_range(0, 3);
        for (int p = 0; p < npk[i]; p++) begin
          int len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) add_beat(i, DW'($urandom), b == len - 1);
        end
        en[i] = 1'b1;
        mp[i] = 0;
      end
      // Packet-level rotation over sources that still hold packets.
      exp_q.delete();
      last = NS - 1;
      any  = 1'b1;
      while (any) begin
        s = -1;
        for (int j = 1; j <= NS && s < 0; j++)
          if (npk[(last + j) % NS] > 0) s = (last + j) % NS;
        if (s < 0) any = 1'b0;
        else begin
          exp_q.push_back({1'b0, DW'(8'hA0 + s)});
          do begin
            exp_q.push_back({sl[s][mp[s]], sd[s][mp[s]]});
            mp[s]++;
          end while (!sl[s][mp[s]-1]);
          npk[s]--;
          last = s;
        end
      end
      cyc = 0;
      prev_stall = 1'b0;
      prev_data  = '0;
      while (exp_q.size() > 0 && cyc < 2000) begin
        step($urandom_range(0, 3) != 0);
        cyc++;
        gmask = NS'(1) << bus.grant_index;
        checks++; if ((bus.in_ready & ~gmask) !== '0) begin failures++; $display("FAIL rand_ready_grant cyc=%0d got=%b grant=%0d", cyc, bus.in_ready, bus.grant_index); end
        if (prev_stall) begin
          checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data) begin failures++; $display("FAIL rand_stall_hold cyc=%0d got=%b/%h exp=1/%h", cyc, bus.out_valid, bus.out_data, prev_data); end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        if (bus.out_valid && bus.out_ready) begin
          e = exp_q.pop_front();
          checks++; if ({bus.out_last, bus.out_data} !== e) begin failures++; $display("FAIL rand_beat round=%0d cyc=%0d got=%b/%h exp=%b/%h", round, cyc, bus.out_last, bus.out_data, e[8], e[7:0]); end
        end
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rand_timeout round=%0d left=%0d exp=0", round, exp_q.size()); end
      for (int i = 0; i < 3; i++) begin
        step(1'b1);
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL rand_drained round=%0d got=%b/%b exp=0/0", round, bus.out_valid, bus.busy); end
      end
    end
  endtask

  initial begin
    clear_sources();
    test_reset();
    test_single_source();
    test_round_robin();
    test_stall();
    test_single_beat_no_tag();
    test_reset_mid_packet();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
